// File: rtl/hls_ctrl_master.sv
// hls_ctrl_master: AXI4-Lite initiator that writes ap_start to the HLS control register and polls for ap_done.
module hls_ctrl_master #(
  parameter int C_S_AXI_CONFIG_ADDR_WIDTH = 5,
  parameter int C_S_AXI_CONFIG_DATA_WIDTH = 32,
  parameter int C_S_AXI_CONFIG_WSTRB_WIDTH = C_S_AXI_CONFIG_DATA_WIDTH / 8,
  parameter logic [C_S_AXI_CONFIG_ADDR_WIDTH-1:0] CTRL_ADDR = '0,
  parameter int POLL_GAP = 4,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic                                  ap_clk,
  input  logic                                  ap_rst_n,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  error,
  output logic [1:0]                            err_code,
  output logic [15:0]                           poll_cnt,
  output logic                                  m_axi_config_AWVALID,
  input  logic                                  m_axi_config_AWREADY,
  output logic [C_S_AXI_CONFIG_ADDR_WIDTH-1:0]  m_axi_config_AWADDR,
  output logic                                  m_axi_config_WVALID,
  input  logic                                  m_axi_config_WREADY,
  output logic [C_S_AXI_CONFIG_DATA_WIDTH-1:0]  m_axi_config_WDATA,
  output logic [C_S_AXI_CONFIG_WSTRB_WIDTH-1:0] m_axi_config_WSTRB,
  input  logic                                  m_axi_config_BVALID,
  output logic                                  m_axi_config_BREADY,
  input  logic [1:0]                            m_axi_config_BRESP,
  output logic                                  m_axi_config_ARVALID,
  input  logic                                  m_axi_config_ARREADY,
  output logic [C_S_AXI_CONFIG_ADDR_WIDTH-1:0]  m_axi_config_ARADDR,
  input  logic                                  m_axi_config_RVALID,
  output logic                                  m_axi_config_RREADY,
  input  logic [C_S_AXI_CONFIG_DATA_WIDTH-1:0]  m_axi_config_RDATA,
  input  logic [1:0]                            m_axi_config_RRESP
);
  typedef enum logic [2:0] {IDLE, WR, WRESP, RD_A, RD_D, GAP} state_t;
  state_t state, state_n;
  logic aw_n, w_n, b_n, ar_n, r_n, busy_n, done_n, err_n, to;
  logic [1:0] code_n;
  logic [15:0] poll_n, tcnt, tcnt_n, gcnt, gcnt_n;
  logic unused_rdata;
  assign unused_rdata = ^{m_axi_config_RDATA[C_S_AXI_CONFIG_DATA_WIDTH-1:2], m_axi_config_RDATA[0]};
  assign to = tcnt == TIMEOUT;
  always_comb begin
    state_n = state;
    aw_n = m_axi_config_AWVALID;
    w_n = m_axi_config_WVALID;
    b_n = 1'b0;
    ar_n = 1'b0;
    r_n = 1'b0;
    busy_n = busy;
    done_n = 1'b0;
    err_n = 1'b0;
    code_n = err_code;
    poll_n = poll_cnt;
    gcnt_n = gcnt;
    // saturates so a timeout reached inside WR/RD_A is still seen once the handshake completes
    tcnt_n = (state == IDLE || to) ? tcnt : tcnt + 16'd1;
    case (state)
      IDLE: if (start) begin
        state_n = WR;
        aw_n = 1'b1;
        w_n = 1'b1;
        busy_n = 1'b1;
        poll_n = '0;
        tcnt_n = '0;
      end
      WR: begin
        aw_n = m_axi_config_AWVALID & ~m_axi_config_AWREADY;
        w_n = m_axi_config_WVALID & ~m_axi_config_WREADY;
        if (!aw_n && !w_n) begin
          state_n = WRESP;
          b_n = 1'b1;
        end
      end
      WRESP: if (m_axi_config_BVALID && m_axi_config_BRESP != 2'b00) begin
        err_n = 1'b1;
        code_n = 2'd1;
      end else if (m_axi_config_BVALID) begin
        state_n = RD_A;
        ar_n = 1'b1;
      end else if (to) begin
        err_n = 1'b1;
        code_n = 2'd3;
      end else b_n = 1'b1;
      RD_A: if (m_axi_config_ARREADY) begin
        state_n = RD_D;
        r_n = 1'b1;
      end else ar_n = 1'b1;
      RD_D: if (m_axi_config_RVALID) begin
        poll_n = (&poll_cnt) ? poll_cnt : poll_cnt + 16'd1;
        if (m_axi_config_RRESP != 2'b00) begin
          err_n = 1'b1;
          code_n = 2'd2;
        end else if (m_axi_config_RDATA[1]) done_n = 1'b1;
        else begin
          state_n = GAP;
          gcnt_n = '0;
        end
      end else if (to) begin
        err_n = 1'b1;
        code_n = 2'd3;
      end else r_n = 1'b1;
      GAP: if (to) begin
        err_n = 1'b1;
        code_n = 2'd3;
      end else if (gcnt == 16'(POLL_GAP - 1)) begin
        state_n = RD_A;
        ar_n = 1'b1;
      end else gcnt_n = gcnt + 16'd1;
      default: state_n = IDLE;
    endcase
    if (done_n || err_n) begin
      state_n = IDLE;
      busy_n = 1'b0;
    end
  end
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state <= IDLE;
      tcnt <= '0;
      gcnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      err_code <= '0;
      poll_cnt <= '0;
      m_axi_config_AWVALID <= 1'b0;
      m_axi_config_WVALID <= 1'b0;
      m_axi_config_BREADY <= 1'b0;
      m_axi_config_ARVALID <= 1'b0;
      m_axi_config_RREADY <= 1'b0;
      m_axi_config_AWADDR <= '0;
      m_axi_config_ARADDR <= '0;
      m_axi_config_WDATA <= '0;
      m_axi_config_WSTRB <= '0;
    end else begin
      state <= state_n;
      tcnt <= tcnt_n;
      gcnt <= gcnt_n;
      busy <= busy_n;
      done <= done_n;
      error <= err_n;
      err_code <= code_n;
      poll_cnt <= poll_n;
      m_axi_config_AWVALID <= aw_n;
      m_axi_config_WVALID <= w_n;
      m_axi_config_BREADY <= b_n;
      m_axi_config_ARVALID <= ar_n;
      m_axi_config_RREADY <= r_n;
      if (state == IDLE && start) begin
        m_axi_config_AWADDR <= CTRL_ADDR;
        m_axi_config_ARADDR <= CTRL_ADDR;
        m_axi_config_WDATA <= C_S_AXI_CONFIG_DATA_WIDTH'(1);
        m_axi_config_WSTRB <= '1;
      end
    end
  end
endmodule

// File: tb/tb_hls_ctrl_master.sv
// tb_hls_ctrl_master: directed runs of the control master against a small configurable AXI4-Lite slave.
module tb_hls_ctrl_master;
  logic ap_clk = 1'b0, ap_rst_n = 1'b0, start = 1'b0;
  logic busy, done, error;
  logic [1:0] err_code;
  logic [15:0] poll_cnt;
  logic AWVALID, AWREADY = 1'b0, WVALID, WREADY = 1'b0, BVALID = 1'b0, BREADY;
  logic ARVALID, ARREADY = 1'b0, RVALID = 1'b0, RREADY;
  logic [4:0] AWADDR, ARADDR;
  logic [31:0] WDATA, RDATA = '0;
  logic [3:0] WSTRB;
  logic [1:0] BRESP = '0, RRESP = '0;
  int n_tests = 0, n_fail = 0;
  int aw_delay, w_delay, b_delay = 1, done_on, rresp_on;
  logic [1:0] bresp_cfg, rresp_val;
  int aw_wait, w_wait, b_wait, rd_idx;
  bit aw_got, w_got, b_hs, ar_hs, r_hs, pend_aw, pend_w, pend_ar;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, vio;
  logic [4:0] last_awaddr;
  logic [31:0] last_wdata;
  logic [3:0] last_wstrb;
  int k_end, k_ar, k_rr;
  logic got_done, got_err;
  logic [1:0] code_end;
  logic [5:0] snap [0:511];

  always #5 ap_clk = ~ap_clk;

  hls_ctrl_master #(.POLL_GAP(4), .TIMEOUT(16'd200)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .poll_cnt(poll_cnt),
    .m_axi_config_AWVALID(AWVALID), .m_axi_config_AWREADY(AWREADY), .m_axi_config_AWADDR(AWADDR),
    .m_axi_config_WVALID(WVALID), .m_axi_config_WREADY(WREADY), .m_axi_config_WDATA(WDATA),
    .m_axi_config_WSTRB(WSTRB),
    .m_axi_config_BVALID(BVALID), .m_axi_config_BREADY(BREADY), .m_axi_config_BRESP(BRESP),
    .m_axi_config_ARVALID(ARVALID), .m_axi_config_ARREADY(ARREADY), .m_axi_config_ARADDR(ARADDR),
    .m_axi_config_RVALID(RVALID), .m_axi_config_RREADY(RREADY), .m_axi_config_RDATA(RDATA),
    .m_axi_config_RRESP(RRESP)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // handshake recorder: sees pre-edge values, as the DUT does
  initial forever begin
    @(posedge ap_clk);
    if (AWVALID && AWREADY) begin aw_cnt++; aw_got = 1; last_awaddr = AWADDR; end
    if (WVALID && WREADY) begin w_cnt++; w_got = 1; last_wdata = WDATA; last_wstrb = WSTRB; end
    if (BVALID && BREADY) begin b_cnt++; b_hs = 1; end
    if (ARVALID && ARREADY) begin ar_cnt++; ar_hs = 1; end
    if (RVALID && RREADY) begin r_cnt++; r_hs = 1; end
    pend_aw = ap_rst_n && AWVALID && !AWREADY;
    pend_w = ap_rst_n && WVALID && !WREADY;
    pend_ar = ap_rst_n && ARVALID && !ARREADY;
  end

  // slave: updates its outputs mid-cycle
  initial forever begin
    @(negedge ap_clk);
    if ((pend_aw && !AWVALID) || (pend_w && !WVALID) || (pend_ar && !ARVALID)) vio++;
    if (AWVALID) begin AWREADY = aw_wait >= aw_delay; aw_wait++; end else begin AWREADY = 0; aw_wait = 0; end
    if (WVALID) begin WREADY = w_wait >= w_delay; w_wait++; end else begin WREADY = 0; w_wait = 0; end
    ARREADY = ARVALID;
    if (b_hs) begin BVALID = 0; b_hs = 0; end
    if (aw_got && w_got) begin
      if (b_wait >= b_delay) begin BVALID = 1; BRESP = bresp_cfg; aw_got = 0; w_got = 0; b_wait = 0; end
      else b_wait++;
    end
    if (r_hs) begin RVALID = 0; r_hs = 0; end
    if (ar_hs) begin
      rd_idx++;
      RVALID = 1;
      RDATA = (rd_idx == done_on) ? 32'h2 : 32'h0;
      RRESP = (rd_idx == rresp_on) ? rresp_val : 2'b00;
      ar_hs = 0;
    end
  end

  task automatic slave_clear(input int awd, input int wd, input logic [1:0] br, input int dn,
                             input int rn, input logic [1:0] rv);
    @(posedge ap_clk);
    #1;
    aw_delay = awd; w_delay = wd; bresp_cfg = br; done_on = dn; rresp_on = rn; rresp_val = rv;
    aw_wait = 0; w_wait = 0; b_wait = 0; rd_idx = 0;
    aw_got = 0; w_got = 0; b_hs = 0; ar_hs = 0; r_hs = 0; pend_aw = 0; pend_w = 0; pend_ar = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; vio = 0;
    last_awaddr = '1; last_wdata = '0; last_wstrb = '0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
  endtask

  // k counts cycles after the one in which start was high; snap[k] is sampled mid-cycle
  task automatic run(input string tag, input int limit, input int mid_k);
    k_end = 0; k_ar = 0; k_rr = 0; got_done = 0; got_err = 0; code_end = 0;
    @(negedge ap_clk);
    start = 1;
    @(negedge ap_clk);
    start = 0;
    for (int k = 1; k <= limit && k_end == 0; k++) begin
      snap[k] = {AWVALID, WVALID, BREADY, ARVALID, RREADY, busy};
      if (ARVALID && k_ar == 0) k_ar = k;
      if (RREADY && k_rr == 0) k_rr = k;
      if (done || error) begin
        k_end = k; got_done = done; got_err = error; code_end = err_code;
      end else begin
        start = (k == mid_k);
        @(negedge ap_clk);
      end
    end
    start = 0;
    chk({tag, "_finished"}, 64'(k_end != 0), 64'(1));
  endtask

  initial begin
    repeat (3) @(negedge ap_clk);
    chk("rst_ctl", 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY, busy, done, error}), 64'(0));
    chk("rst_code_poll", 64'({err_code, poll_cnt}), 64'(0));
    chk("rst_addr_data", 64'({AWADDR, ARADDR, WDATA, WSTRB}), 64'(0));
    ap_rst_n = 1;

    // zero-wait slave, ap_done on third read, stray start while busy
    slave_clear(0, 0, 2'b00, 3, 0, 2'b00);
    run("t1", 100, 3);
    chk("t1_launch", 64'(snap[1]), 64'(6'b110001));
    chk("t1_wresp", 64'(snap[2]), 64'(6'b001001));
    chk("t1_first_ar", 64'(k_ar), 64'(4));
    chk("t1_first_r", 64'(k_rr), 64'(5));
    chk("t1_end_cycle", 64'(k_end), 64'(18));
    chk("t1_done_err", 64'({got_done, got_err}), 64'(2'b10));
    chk("t1_end_outputs", 64'(snap[k_end]), 64'(0));
    chk("t1_counts", 64'({8'(aw_cnt), 8'(w_cnt), 8'(b_cnt), 8'(ar_cnt), 8'(r_cnt)}), 64'(40'h0101010303));
    chk("t1_write", 64'({last_awaddr, last_wdata, last_wstrb}), 64'({5'h00, 32'h1, 4'hF}));
    chk("t1_poll_cnt", 64'(poll_cnt), 64'(3));
    chk("t1_vio", 64'(vio), 64'(0));
    @(negedge ap_clk);
    chk("t1_done_pulse", 64'(done), 64'(0));
    repeat (8) @(negedge ap_clk);
    chk("t1_start_not_queued", 64'({8'(aw_cnt), 7'(0), busy}), 64'(16'h0100));

    // AWREADY three cycles after WREADY
    slave_clear(3, 0, 2'b00, 1, 0, 2'b00);
    run("t2", 100, 0);
    chk("t2_w_dropped", 64'(snap[2]), 64'(6'b100001));
    chk("t2_aw_held", 64'(snap[4]), 64'(6'b100001));
    chk("t2_wresp", 64'(snap[5]), 64'(6'b001001));
    chk("t2_end_cycle", 64'({k_end, 30'(0), got_done, got_err}), 64'({32'(9), 32'h2}));
    chk("t2_counts", 64'({8'(aw_cnt), 8'(w_cnt), 8'(b_cnt), 8'(vio)}), 64'(32'h01010100));

    // BRESP error
    slave_clear(0, 0, 2'b10, 1, 0, 2'b00);
    run("t3", 100, 0);
    chk("t3_err", 64'({got_done, got_err, code_end}), 64'(4'b0101));
    chk("t3_end_cycle", 64'(k_end), 64'(4));
    chk("t3_end_outputs", 64'(snap[k_end]), 64'(0));
    @(negedge ap_clk);
    chk("t3_no_ar", 64'({8'(ar_cnt), 7'(0), error}), 64'(0));

    // RRESP error on second read, which also carries ap_done
    slave_clear(0, 0, 2'b00, 2, 2, 2'b11);
    run("t4", 100, 0);
    chk("t4_err", 64'({got_done, got_err, code_end}), 64'(4'b0110));
    chk("t4_end_cycle", 64'(k_end), 64'(12));
    chk("t4_poll_cnt", 64'(poll_cnt), 64'(2));

    // ap_done never set: timeout lands in GAP at cycle 201
    slave_clear(0, 0, 2'b00, 0, 0, 2'b00);
    run("t5", 300, 0);
    chk("t5_err", 64'({got_done, got_err, code_end}), 64'(4'b0111));
    chk("t5_end_cycle", 64'(k_end), 64'(202));
    chk("t5_poll_cnt", 64'(poll_cnt), 64'(33));
    chk("t5_vio", 64'(vio), 64'(0));
    chk("t5_end_outputs", 64'(snap[k_end]), 64'(0));

    // reset during RD_D, then a clean run
    slave_clear(0, 0, 2'b00, 0, 0, 2'b00);
    @(negedge ap_clk);
    start = 1;
    @(negedge ap_clk);
    start = 0;
    repeat (4) @(negedge ap_clk);
    chk("t6_in_rd_d", 64'({ARVALID, RREADY, busy}), 64'(3'b011));
    ap_rst_n = 0;
    @(negedge ap_clk);
    chk("t6_rst_ctl", 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY, busy, done, error}), 64'(0));
    chk("t6_rst_code_poll", 64'({err_code, poll_cnt}), 64'(0));
    ap_rst_n = 1;
    slave_clear(0, 0, 2'b00, 1, 0, 2'b00);
    run("t6", 100, 0);
    chk("t6_clean", 64'({k_end, 30'(0), got_done, got_err}), 64'({32'(6), 32'h2}));
    chk("t6_poll_cnt", 64'({poll_cnt, 8'(aw_cnt)}), 64'(24'h000101));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hls_ctrl_master.md
# hls_ctrl_master

AXI4-Lite initiator that drives the `s_axi_config` control slave of the HLS Gaussian-blur target (`hls_target`). On a single start request it writes `ap_start` to the control register. It then polls that register by read until `ap_done` is observed and reports completion, bus error, or timeout. It sits in the equivalence/simulation harness in place of a free testbench driver, so the HLS side can be launched deterministically alongside the ILA model.

## Interface
- `C_S_AXI_CONFIG_ADDR_WIDTH`, 5, config address width
- `C_S_AXI_CONFIG_DATA_WIDTH`, 32, config data width
- `C_S_AXI_CONFIG_WSTRB_WIDTH`, DATA_WIDTH/8, write-strobe width
- `CTRL_ADDR`, 5'h00, address of the ap_ctrl register
- `POLL_GAP`, 4, idle cycles between consecutive polls (≥1)
- `TIMEOUT`, 16'hFFFF, max cycles from accepted start to done

Ports:
- `ap_clk`  in  1  clock
- `ap_rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  launch request; sampled only in IDLE
- `busy`  out  1  high from the cycle after an accepted start until DONE/ERR is reported
- `done`  out  1  one-cycle pulse: ap_done seen
- `error`  out  1  one-cycle pulse: nonzero BRESP/RRESP or timeout
- `err_code`  out  2  valid with `error`: 1=BRESP, 2=RRESP, 3=timeout
- `poll_cnt`  out  16  number of completed reads in the current/last run
- `m_axi_config_AWVALID/AWREADY/AWADDR`  out/in/out  1/1/ADDR  write address channel
- `m_axi_config_WVALID/WREADY/WDATA/WSTRB`  out/in/out/out  1/1/DATA/WSTRB  write data channel
- `m_axi_config_BVALID/BREADY/BRESP`  in/out/in  1/1/2  write response
- `m_axi_config_ARVALID/ARREADY/ARADDR`  out/in/out  1/1/ADDR  read address
- `m_axi_config_RVALID/RREADY/RDATA/RRESP`  in/out/in/in  1/1/DATA/2  read data

## Operation
- States: IDLE, WR, WRESP, RD_A, RD_D, GAP.
- IDLE: if `start`, go to WR, clear `poll_cnt`, clear the timeout counter.
- WR: assert AWVALID with AWADDR=CTRL_ADDR and WVALID with WDATA=32'h1 and WSTRB all-ones. Drop each VALID independently in the cycle after its own handshake (VALID&READY). Move to WRESP when both handshakes are complete; if both complete in the same cycle, move directly.
- WRESP: BREADY=1. On BVALID, BRESP≠0 gives `error`, code 1, then IDLE. Otherwise go to RD_A.
- RD_A: ARVALID=1 with ARADDR=CTRL_ADDR. On ARREADY, go to RD_D.
- RD_D: RREADY=1. On RVALID, increment `poll_cnt` (saturating). Then, in priority order:
  - RRESP≠0: `error`, code 2, IDLE.
  - RDATA[1] (ap_done)=1: `done`, IDLE.
  - Otherwise: GAP.
- GAP: wait POLL_GAP cycles, then RD_A.
- Timeout: a 16-bit counter runs in every non-IDLE state. On reaching TIMEOUT, issue `error` code 3 and return to IDLE, but only from WRESP, RD_D (without a response that cycle) or GAP. WR and RD_A hold until their handshakes complete, so AXI VALID is never withdrawn.
- A response arriving in the same cycle as the timeout wins over the timeout.
- VALIDs never depend combinationally on READY. BREADY/RREADY are asserted only in their own states.
- All AXI outputs are registered.

## Timing
- Reset values: all VALIDs and READYs 0; `busy`, `done`, `error` 0; `err_code` 0; `poll_cnt` 0; addresses and WDATA 0; state IDLE.
- Reset asserted mid-transaction aborts in the next cycle with no completion pulse. Slave recovery is the harness's responsibility.
- `start` in cycle t gives AWVALID/WVALID high in cycle t+1.
- With a zero-wait slave, the first ARVALID occurs at t+4. The first RDATA is sampled at t+5.
- Each unsuccessful poll costs 2 + POLL_GAP cycles plus slave wait states.
- `done`/`error` pulse in the cycle after the deciding response; `busy` falls in that same cycle.
- `start` asserted while busy is ignored; it is not queued.

## Test plan
- Zero-wait slave, ap_done set on the 3rd read. Required: one write of 0x1 to 0x00, three reads, `done` pulse, `poll_cnt`=3, zero errors.
- AWREADY 3 cycles after WREADY. Required: WVALID drops after its own handshake, AWVALID holds until accepted, exactly one BREADY handshake.
- BRESP=2'b10. Required: `error` with `err_code`=1, no AR issued, `busy` low next cycle.
- Second read returns RRESP=2'b11 with RDATA[1]=1. Required: `error` code 2, no `done`.
- Slave never sets ap_done, TIMEOUT=200. Required: `error` code 3 within 200+2+POLL_GAP cycles, from GAP/RD_D only, with no VALID dropped un-handshaken.
- `ap_rst_n` low during RD_D. Required: all outputs at reset values next cycle. A later `start` runs a clean sequence with `poll_cnt` restarting from 0.
